// File: rtl/sd_spi_xfer_ctrl.sv
// SD card SPI block-transfer sequencer: streams 32-bit sector-buffer words MSB-first
// over SPI mode 0 (TX), or assembles MISO bits into buffer words (RX).
module sd_spi_xfer_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_dir,
    input  logic [ADDR_W-1:0] i_length,
    input  logic [7:0]        i_clk_div,
    input  logic              i_cs_enable,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sd_clk,
    output logic              o_sd_cs,
    output logic              o_sd_mosi,
    input  logic              i_sd_miso,
    output logic [ADDR_W-1:0] o_buf_address,
    output logic [31:0]       o_buf_data,
    output logic              o_buf_wren,
    input  logic [31:0]       i_buf_q
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, STORE, DONE} state_t;

    state_t            state_reg, state_next;
    logic              dir_reg, dir_next;
    logic [ADDR_W-1:0] length_reg, length_next;
    logic [7:0]        div_reg, div_next;
    logic [ADDR_W-1:0] index_reg, index_next;
    logic [31:0]       sr_reg, sr_next;
    logic [5:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        div_cnt_reg, div_cnt_next;
    logic              sd_clk_reg, sd_clk_next;
    logic              mosi_reg, mosi_next;
    logic              cs_reg, cs_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [ADDR_W-1:0] buf_address_reg, buf_address_next;
    logic [31:0]       buf_data_reg, buf_data_next;
    logic              wren_reg, wren_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg       <= IDLE;
            dir_reg         <= 1'b0;
            length_reg      <= '0;
            div_reg         <= '0;
            index_reg       <= '0;
            sr_reg          <= '0;
            bit_cnt_reg     <= '0;
            div_cnt_reg     <= '0;
            sd_clk_reg      <= 1'b0;
            mosi_reg        <= 1'b1;
            cs_reg          <= 1'b1;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            buf_address_reg <= '0;
            buf_data_reg    <= '0;
            wren_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            dir_reg         <= dir_next;
            length_reg      <= length_next;
            div_reg         <= div_next;
            index_reg       <= index_next;
            sr_reg          <= sr_next;
            bit_cnt_reg     <= bit_cnt_next;
            div_cnt_reg     <= div_cnt_next;
            sd_clk_reg      <= sd_clk_next;
            mosi_reg        <= mosi_next;
            cs_reg          <= cs_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            buf_address_reg <= buf_address_next;
            buf_data_reg    <= buf_data_next;
            wren_reg        <= wren_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        dir_next         = dir_reg;
        length_next      = length_reg;
        div_next         = div_reg;
        index_next       = index_reg;
        sr_next          = sr_reg;
        bit_cnt_next     = bit_cnt_reg;
        div_cnt_next     = div_cnt_reg;
        sd_clk_next      = sd_clk_reg;
        mosi_next        = mosi_reg;
        cs_next          = ~i_cs_enable;
        busy_next        = busy_reg;
        done_next        = 1'b0;
        buf_address_next = buf_address_reg;
        buf_data_next    = buf_data_reg;
        wren_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    dir_next    = i_dir;
                    length_next = i_length;
                    div_next    = i_clk_div;
                    index_next  = '0;
                    busy_next   = 1'b1;
                    if (i_dir) begin
                        state_next = LOAD;
                    end else begin
                        // Address is presented on FETCH entry so the RAM word lands in LOAD.
                        buf_address_next = '0;
                        state_next       = FETCH;
                    end
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                if (dir_reg) begin
                    sr_next   = '0;
                    mosi_next = 1'b1;
                end else begin
                    sr_next   = i_buf_q;
                    mosi_next = i_buf_q[31];
                end
                bit_cnt_next = '0;
                div_cnt_next = '0;
                state_next   = SHIFT;
            end
            SHIFT: begin
                if (div_cnt_reg == div_reg) begin
                    div_cnt_next = '0;
                    sd_clk_next  = ~sd_clk_reg;
                    if (!sd_clk_reg) begin
                        sr_next = {sr_reg[30:0], i_sd_miso};
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                        if (bit_cnt_reg == 6'd31) begin
                            state_next = STORE;
                            if (dir_reg) begin
                                buf_address_next = index_reg;
                                buf_data_next    = sr_reg;
                                wren_next        = 1'b1;
                            end
                        end else begin
                            // sr[31] already holds the next TX bit after the rising-edge shift.
                            mosi_next = dir_reg ? 1'b1 : sr_reg[31];
                        end
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end
            end
            STORE: begin
                if (index_reg == length_reg) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    mosi_next  = 1'b1;
                end else begin
                    index_next = index_reg + 1'b1;
                    if (dir_reg) begin
                        state_next = LOAD;
                    end else begin
                        buf_address_next = index_reg + 1'b1;
                        state_next       = FETCH;
                    end
                end
            end
            DONE: begin
                mosi_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_busy        = busy_reg;
    assign o_done        = done_reg;
    assign o_sd_clk      = sd_clk_reg;
    assign o_sd_cs       = cs_reg;
    assign o_sd_mosi     = mosi_reg;
    assign o_buf_address = buf_address_reg;
    assign o_buf_data    = buf_data_reg;
    assign o_buf_wren    = wren_reg;

endmodule

// File: tb/tb_sd_spi_xfer_ctrl.sv
// Self-checking bench for sd_spi_xfer_ctrl: buffer RAM and SD card models, with
// expected bit streams and buffer writes computed directly from the word lists.
module tb_sd_spi_xfer_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [7:0]  length;
    logic [7:0]  clk_div;
    logic        cs_enable;
    logic        busy, done, sd_clk, sd_cs, mosi;
    logic        miso = 1'b1;
    logic [7:0]  buf_address;
    logic [31:0] buf_data;
    logic        wren;
    logic [31:0] buf_q;

    always #5 clk = ~clk;

    sd_spi_xfer_ctrl #(.ADDR_W(8)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_dir(dir), .i_length(length),
        .i_clk_div(clk_div), .i_cs_enable(cs_enable), .o_busy(busy), .o_done(done),
        .o_sd_clk(sd_clk), .o_sd_cs(sd_cs), .o_sd_mosi(mosi), .i_sd_miso(miso),
        .o_buf_address(buf_address), .o_buf_data(buf_data), .o_buf_wren(wren),
        .i_buf_q(buf_q)
    );

    // Buffer RAM port A: registered read, writes only logged
    logic [31:0] mem [0:255];
    always @(posedge clk) buf_q <= mem[buf_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    // Monitor state
    logic        mon_prev_clk = 1'b0;
    int          rise_cnt, done_cnt, busy_at_done, mosi_low_cnt, last_edge_cyc, wr_at_done;
    bit          check_mosi_high;
    bit          mosi_log[$];
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          high_durs[$];
    int          low_durs[$];
    bit          rx_bits[$];
    int          rx_pos;
    logic [31:0] rx_words[$];

    always @(negedge clk) begin
        if (sd_clk !== mon_prev_clk) begin
            if (mon_prev_clk === 1'b1) high_durs.push_back(cyc - last_edge_cyc);
            else low_durs.push_back(cyc - last_edge_cyc);
            last_edge_cyc = cyc;
            if (sd_clk === 1'b1) begin
                rise_cnt++;
                mosi_log.push_back(mosi);
                rx_pos++;
            end
            mon_prev_clk = sd_clk;
        end
        miso = (rx_pos < rx_bits.size()) ? rx_bits[rx_pos] : 1'b1;
        if (wren === 1'b1) begin
            wr_addr.push_back(buf_address);
            wr_data.push_back(buf_data);
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b0) busy_at_done++;
            wr_at_done = wr_addr.size();
        end
        if (check_mosi_high && mosi !== 1'b1) mosi_low_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        rise_cnt = 0; done_cnt = 0; busy_at_done = 0; mosi_low_cnt = 0; wr_at_done = 0;
        check_mosi_high = 1'b0;
        mosi_log.delete(); wr_addr.delete(); wr_data.delete();
        high_durs.delete(); low_durs.delete(); rx_bits.delete();
        rx_pos = 0;
    endtask

    // Card-side MISO stream, MSB-first per word
    task automatic load_rx_bits();
        for (int w = 0; w < rx_words.size(); w++) begin
            logic [31:0] word;
            word = rx_words[w];
            for (int b = 31; b >= 0; b--) rx_bits.push_back(word[b]);
        end
    endtask

    task automatic do_start(input bit d, input int len, input int div);
        @(negedge clk);
        start = 1'b1; dir = d; length = 8'(len); clk_div = 8'(div);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        int n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt != 0);
        repeat (6) @(negedge clk);
    endtask

    task automatic run_xfer(input bit d, input int len, input int div, output bit ok);
        clear_logs();
        load_rx_bits();
        check_mosi_high = d;
        do_start(d, len, div);
        wait_done(200 * (len + 1) * (div + 1) + 100, ok);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dir = 1'b0; length = '0; clk_div = '0; cs_enable = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, sd_clk, sd_cs, mosi, wren} !== 6'b000110) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got busy/done/clk/cs/mosi/wren=%b want 000110",
                     {busy, done, sd_clk, sd_cs, mosi, wren});
        end
        tests_run++;
        if (buf_address !== 8'h00 || buf_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_buf: got addr=%h data=%h want 00/00000000", buf_address, buf_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cs();
        cs_enable = 1'b1;
        #1;
        tests_run++;
        if (sd_cs !== 1'b1) begin
            tests_failed++;
            $display("FAIL cs_latency: got cs=%b before clock edge want 1", sd_cs);
        end
        @(negedge clk);
        tests_run++;
        if (sd_cs !== 1'b0) begin
            tests_failed++;
            $display("FAIL cs_assert: got cs=%b want 0", sd_cs);
        end
        cs_enable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (sd_cs !== 1'b1) begin
            tests_failed++;
            $display("FAIL cs_release: got cs=%b want 1", sd_cs);
        end
        cs_enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tx_fixed();
        bit ok;
        logic [31:0] got;
        int bad_high;
        mem[0] = 32'hA5C3_0F01;
        clear_logs();
        do_start(1'b0, 0, 0);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_fixed_busy: got busy=%b after start want 1", busy);
        end
        wait_done(500, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL tx_fixed_timeout: got no done want done");
        end
        tests_run++;
        if (rise_cnt != 32) begin
            tests_failed++;
            $display("FAIL tx_fixed_rises: got %0d want 32", rise_cnt);
        end
        got = '0;
        for (int i = 0; i < 32 && i < mosi_log.size(); i++) got = {got[30:0], mosi_log[i]};
        tests_run++;
        if (got !== 32'hA5C3_0F01) begin
            tests_failed++;
            $display("FAIL tx_fixed_mosi: got %h want a5c30f01", got);
        end
        tests_run++;
        if (done_cnt != 1 || busy_at_done != 0 || wr_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL tx_fixed_done: got done=%0d busy_at_done=%0d writes=%0d want 1/0/0",
                     done_cnt, busy_at_done, wr_addr.size());
        end
        bad_high = 0;
        foreach (high_durs[i]) if (high_durs[i] != 1) bad_high++;
        tests_run++;
        if (bad_high != 0 || high_durs.size() != 32) begin
            tests_failed++;
            $display("FAIL tx_fixed_div0: got %0d high phases, %0d not 1 cycle; want 32, 0",
                     high_durs.size(), bad_high);
        end
        $display("[TB] tx fixed word: rises=%0d mosi=%h", rise_cnt, got);
    endtask

    task automatic test_rx_two();
        bit ok;
        rx_words = '{32'hDEAD_BEEF, 32'h1234_5678};
        run_xfer(1'b1, 1, 1, ok);
        tests_run++;
        if (!ok || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL rx_two_done: got done_cnt=%0d want 1", done_cnt);
        end
        tests_run++;
        if (wr_addr.size() != 2) begin
            tests_failed++;
            $display("FAIL rx_two_count: got %0d writes want 2", wr_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== rx_words[i]) begin
                    tests_failed++;
                    $display("FAIL rx_two_write%0d: got %h@%h want %h@%h",
                             i, wr_data[i], wr_addr[i], rx_words[i], 8'(i));
                end
            end
        end
        tests_run++;
        if (mosi_low_cnt != 0) begin
            tests_failed++;
            $display("FAIL rx_two_mosi: got %0d cycles with mosi!=1 want 0", mosi_low_cnt);
        end
        $display("[TB] rx two words: writes=%0d", wr_addr.size());
    endtask

    task automatic test_div3();
        bit ok;
        int bad_high, bad_low;
        mem[0] = $urandom;
        clear_logs();
        do_start(1'b0, 0, 3);
        clk_div = 8'd0;
        wait_done(1000, ok);
        bad_high = 0; bad_low = 0;
        foreach (high_durs[i]) if (high_durs[i] != 4) bad_high++;
        for (int i = 1; i < low_durs.size(); i++) if (low_durs[i] != 4) bad_low++;
        tests_run++;
        if (!ok || high_durs.size() != 32 || bad_high != 0) begin
            tests_failed++;
            $display("FAIL div3_high: got %0d high phases, %0d not 4 cycles; want 32, 0",
                     high_durs.size(), bad_high);
        end
        tests_run++;
        if (low_durs.size() != 32 || bad_low != 0) begin
            tests_failed++;
            $display("FAIL div3_low: got %0d low phases, %0d inner not 4 cycles; want 32, 0",
                     low_durs.size(), bad_low);
        end
        $display("[TB] div3 with mid-transfer div change: high=%0d low=%0d", high_durs.size(), low_durs.size());
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            bit ok, d;
            int len, div, nbad;
            d   = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 3);
            div = $urandom_range(0, 2);
            rx_words.delete();
            for (int w = 0; w <= len; w++) begin
                mem[w] = $urandom;
                rx_words.push_back($urandom);
            end
            run_xfer(d, len, div, ok);
            nbad = 0;
            if (d) begin
                if (wr_addr.size() != len + 1) nbad++;
                else for (int w = 0; w <= len; w++)
                    if (wr_addr[w] !== 8'(w) || wr_data[w] !== rx_words[w]) nbad++;
                if (mosi_low_cnt != 0) nbad++;
            end else begin
                if (mosi_log.size() != 32 * (len + 1) || wr_addr.size() != 0) nbad++;
                else for (int w = 0; w <= len; w++) begin
                    logic [31:0] word;
                    word = mem[w];
                    for (int b = 0; b < 32; b++)
                        if (mosi_log[w * 32 + b] !== word[31 - b]) nbad++;
                end
            end
            tests_run++;
            if (!ok || done_cnt != 1 || nbad != 0) begin
                tests_failed++;
                $display("FAIL random%0d: dir=%0d len=%0d div=%0d got done=%0d errors=%0d want done=1 errors=0",
                         t, d, len, div, done_cnt, nbad);
            end
            $display("[TB] random dir=%0d len=%0d div=%0d rises=%0d writes=%0d",
                     d, len, div, rise_cnt, wr_addr.size());
        end
    endtask

    task automatic test_long_rx();
        bit ok;
        int nbad;
        rx_words.delete();
        for (int w = 0; w < 256; w++) rx_words.push_back($urandom);
        run_xfer(1'b1, 255, 0, ok);
        tests_run++;
        if (wr_addr.size() != 256) begin
            tests_failed++;
            $display("FAIL long_count: got %0d writes want 256", wr_addr.size());
        end
        nbad = 0;
        for (int w = 0; w < 256 && w < wr_addr.size(); w++)
            if (wr_addr[w] !== 8'(w) || wr_data[w] !== rx_words[w]) nbad++;
        tests_run++;
        if (nbad != 0) begin
            tests_failed++;
            $display("FAIL long_data: got %0d wrong writes want 0", nbad);
        end
        tests_run++;
        if (!ok || done_cnt != 1 || wr_at_done != 256) begin
            tests_failed++;
            $display("FAIL long_done: got done=%0d writes_at_done=%0d want 1/256", done_cnt, wr_at_done);
        end
        $display("[TB] rx 256 words: writes=%0d", wr_addr.size());
    endtask

    task automatic test_busy_ignore();
        bit ok;
        int nbad;
        mem[0] = $urandom; mem[1] = $urandom;
        clear_logs();
        do_start(1'b0, 1, 1);
        repeat (20) @(negedge clk);
        start = 1'b1; dir = 1'b1; length = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(1000, ok);
        nbad = 0;
        if (mosi_log.size() != 64) nbad++;
        else for (int w = 0; w < 2; w++) begin
            logic [31:0] word;
            word = mem[w];
            for (int b = 0; b < 32; b++) if (mosi_log[w * 32 + b] !== word[31 - b]) nbad++;
        end
        tests_run++;
        if (!ok || done_cnt != 1 || wr_addr.size() != 0 || nbad != 0) begin
            tests_failed++;
            $display("FAIL busy_ignore: got done=%0d writes=%0d bit_errors=%0d want 1/0/0",
                     done_cnt, wr_addr.size(), nbad);
        end
        repeat (50) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || rise_cnt != 64) begin
            tests_failed++;
            $display("FAIL busy_ignore_after: got busy=%b rises=%0d want 0/64", busy, rise_cnt);
        end
        $display("[TB] second start while busy: rises=%0d writes=%0d", rise_cnt, wr_addr.size());
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        rx_words = '{32'hCAFE_F00D, 32'h0BAD_CAFE, 32'h1111_2222, 32'h3333_4444};
        clear_logs();
        load_rx_bits();
        do_start(1'b1, 3, 1);
        n = 0;
        while (rise_cnt < 10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (rise_cnt < 10) begin
            tests_failed++;
            $display("FAIL reset_mid_wait: got %0d rises want 10", rise_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({sd_clk, mosi, busy, wren} !== 4'b0100) begin
            tests_failed++;
            $display("FAIL reset_mid_state: got clk/mosi/busy/wren=%b want 0100", {sd_clk, mosi, busy, wren});
        end
        rst = 1'b0;
        repeat (100) @(negedge clk);
        tests_run++;
        if (done_cnt != 0 || wr_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: got done=%0d writes=%0d want 0/0", done_cnt, wr_addr.size());
        end
        rx_words = '{32'h8765_4321};
        run_xfer(1'b1, 0, 1, ok);
        tests_run++;
        if (!ok || done_cnt != 1 || wr_addr.size() != 1 || wr_data[0] !== 32'h8765_4321 || wr_addr[0] !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: got done=%0d writes=%0d want 1/1 of 87654321@00",
                     done_cnt, wr_addr.size());
        end
        $display("[TB] reset mid-transfer then restart: writes=%0d", wr_addr.size());
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        clear_logs();
        test_reset();
        test_cs();
        test_tx_fixed();
        test_rx_two();
        test_div3();
        test_random();
        test_busy_ignore();
        test_long_rx();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
